// File: rtl/sram_axi_slave.sv
// sram_axi_slave: AXI4 slave endpoint that converts one AXI burst at a time
// into accesses on a single-port synchronous SRAM macro (1-cycle read
// latency, active-low CEB/WEB/BWEB).
//
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   AW*/W*/B*                AXI4 write address / data / response channels
//   AR*/R*                   AXI4 read address / data channels
//   CEB, WEB, BWEB, A, DI    SRAM controls, word address and write data
//   DO                       SRAM read data (valid the cycle after a read)
//
// Build option:
//   SRAM_AXI_SLAVE_RDATA_REG_EN  register RDATA from DO (first RVALID two
//                                cycles after AR); undefined: RDATA = DO.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module sram_axi_slave #(
    parameter int unsigned SRAM_AW = 14,
    parameter int unsigned SRAM_DW = 32
) (
    input  logic                        ACLK,
    input  logic                        ARESETn,
    // write address channel
    input  logic [`AXI_IDS_BITS-1:0]    AWID,
    input  logic [`AXI_ADDR_BITS-1:0]   AWADDR,
    input  logic [`AXI_LEN_BITS-1:0]    AWLEN,
    input  logic [`AXI_SIZE_BITS-1:0]   AWSIZE,
    input  logic [1:0]                  AWBURST,
    input  logic                        AWVALID,
    output logic                        AWREADY,
    // write data channel
    input  logic [`AXI_DATA_BITS-1:0]   WDATA,
    input  logic [`AXI_STRB_BITS-1:0]   WSTRB,
    input  logic                        WLAST,
    input  logic                        WVALID,
    output logic                        WREADY,
    // write response channel
    output logic [`AXI_IDS_BITS-1:0]    BID,
    output logic [1:0]                  BRESP,
    output logic                        BVALID,
    input  logic                        BREADY,
    // read address channel
    input  logic [`AXI_IDS_BITS-1:0]    ARID,
    input  logic [`AXI_ADDR_BITS-1:0]   ARADDR,
    input  logic [`AXI_LEN_BITS-1:0]    ARLEN,
    input  logic [`AXI_SIZE_BITS-1:0]   ARSIZE,
    input  logic [1:0]                  ARBURST,
    input  logic                        ARVALID,
    output logic                        ARREADY,
    // read data channel
    output logic [`AXI_IDS_BITS-1:0]    RID,
    output logic [`AXI_DATA_BITS-1:0]   RDATA,
    output logic [1:0]                  RRESP,
    output logic                        RLAST,
    output logic                        RVALID,
    input  logic                        RREADY,
    // SRAM macro
    output logic                        CEB,
    output logic                        WEB,
    output logic [SRAM_DW-1:0]          BWEB,
    output logic [SRAM_AW-1:0]          A,
    output logic [SRAM_DW-1:0]          DI,
    input  logic [SRAM_DW-1:0]          DO
);

    localparam int unsigned IDW   = `AXI_IDS_BITS;
    localparam int unsigned ADDRW = `AXI_ADDR_BITS;
    localparam int unsigned LENW  = `AXI_LEN_BITS;
    localparam int unsigned DATAW = `AXI_DATA_BITS;
    localparam int unsigned STRBW = `AXI_STRB_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_WR    = 2'd2,
        S_WRESP = 2'd3
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_id;
    logic [SRAM_AW-1:0] r_addr;
    logic [LENW-1:0]    r_len;
    logic [LENW-1:0]    r_cnt;
    logic [1:0]         r_burst;
    logic               r_bresp_err;

    logic               w_aw_hs;
    logic               w_ar_hs;
    logic               w_wbeat;
    logic               w_rlast;
    logic               w_rvalid;
    logic               w_rhs;
    logic               w_radv;
    logic [SRAM_AW-1:0] w_addr_next;
    logic [SRAM_AW-1:0] w_aw_word;
    logic [SRAM_AW-1:0] w_ar_word;
    logic [DATAW-1:0]   w_rdata;
    logic               w_unused;

    assign w_aw_word   = AWADDR[SRAM_AW+1:2];
    assign w_ar_word   = ARADDR[SRAM_AW+1:2];
    // FIXED holds; INCR and WRAP both step by one word with natural wrap
    assign w_addr_next = (r_burst == 2'b00) ? r_addr : r_addr + SRAM_AW'(1);
    assign w_rlast     = (r_cnt == r_len);
    assign w_wbeat     = (r_state == S_WR) && WVALID;

    // Ready only in IDLE; the write wins a simultaneous request
    assign AWREADY = ARESETn && (r_state == S_IDLE);
    assign ARREADY = ARESETn && (r_state == S_IDLE) && !(AWVALID && ARVALID);
    assign w_aw_hs = AWVALID && AWREADY;
    assign w_ar_hs = ARVALID && ARREADY;

`ifdef SRAM_AXI_SLAVE_RDATA_REG_EN
    logic [DATAW-1:0]   r_rdata;
    logic               r_rv;
    logic               r_ld_done;
    logic [LENW-1:0]    r_lcnt;

    assign w_rvalid = r_rv;
    assign w_rhs    = r_rv && RREADY;
    // Load DO when the output register is empty or draining this cycle
    assign w_radv   = (r_state == S_RD) && !r_ld_done && (!r_rv || RREADY);
    assign w_rdata  = r_rdata;
`else
    assign w_rvalid = (r_state == S_RD);
    assign w_rhs    = w_rvalid && RREADY;
    // Step to the next beat only on a non-last handshake so DO stays put
    assign w_radv   = w_rhs && !w_rlast;
    assign w_rdata  = DATAW'(DO);
`endif

    // Main FSM and transaction context
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= S_IDLE;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_burst     <= '0;
            r_bresp_err <= 1'b0;
`ifdef SRAM_AXI_SLAVE_RDATA_REG_EN
            r_rdata     <= '0;
            r_rv        <= 1'b0;
            r_ld_done   <= 1'b0;
            r_lcnt      <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_id        <= AWID;
                        r_addr      <= w_aw_word;
                        r_len       <= AWLEN;
                        r_burst     <= AWBURST;
                        r_cnt       <= '0;
                        r_bresp_err <= 1'b0;
                        r_state     <= S_WR;
                    end else if (w_ar_hs) begin
                        r_id        <= ARID;
                        r_addr      <= w_ar_word;
                        r_len       <= ARLEN;
                        r_burst     <= ARBURST;
                        r_cnt       <= '0;
`ifdef SRAM_AXI_SLAVE_RDATA_REG_EN
                        r_rv        <= 1'b0;
                        r_ld_done   <= 1'b0;
                        r_lcnt      <= '0;
`endif
                        r_state     <= S_RD;
                    end
                end
                S_RD: begin
                    if (w_radv) begin
                        r_addr <= w_addr_next;
                    end
`ifdef SRAM_AXI_SLAVE_RDATA_REG_EN
                    if (w_radv) begin
                        r_rdata <= DATAW'(DO);
                        r_rv    <= 1'b1;
                        r_lcnt  <= r_lcnt + LENW'(1);
                        if (r_lcnt == r_len) begin
                            r_ld_done <= 1'b1;
                        end
                    end else if (w_rhs) begin
                        r_rv <= 1'b0;
                    end
`endif
                    if (w_rhs) begin
                        if (w_rlast) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + LENW'(1);
                        end
                    end
                end
                S_WR: begin
                    if (w_wbeat) begin
                        r_addr <= w_addr_next;
                        r_cnt  <= r_cnt + LENW'(1);
                        if (WLAST) begin
                            r_bresp_err <= (r_cnt != r_len);
                            r_state     <= S_WRESP;
                        end
                    end
                end
                S_WRESP: begin
                    if (BREADY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // SRAM control decode; address is looked ahead on read beats
    always_comb begin
        CEB  = 1'b1;
        WEB  = 1'b1;
        BWEB = '1;
        A    = r_addr;
        DI   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_ar_hs) begin
                    CEB = 1'b0;
                    A   = w_ar_word;
                end
            end
            S_RD: begin
                CEB = 1'b0;
                A   = w_radv ? w_addr_next : r_addr;
            end
            S_WR: begin
                if (WVALID) begin
                    CEB = 1'b0;
                    WEB = 1'b0;
                    DI  = SRAM_DW'(WDATA);
                    for (int k = 0; k < STRBW; k++) begin
                        BWEB[8*k +: 8] = {8{~WSTRB[k]}};
                    end
                end
            end
            default: ;
        endcase
    end

    assign WREADY = (r_state == S_WR);
    assign BVALID = (r_state == S_WRESP);
    assign BID    = BVALID ? r_id : '0;
    assign BRESP  = (BVALID && r_bresp_err) ? 2'b10 : 2'b00;

    assign RVALID = w_rvalid;
    assign RDATA  = w_rvalid ? w_rdata : '0;
    assign RID    = w_rvalid ? r_id : '0;
    assign RRESP  = 2'b00;
    assign RLAST  = w_rvalid && w_rlast;

    // Size is ignored and only the word-index address bits are decoded
    assign w_unused = ^{AWSIZE, ARSIZE,
                        AWADDR[ADDRW-1:SRAM_AW+2], AWADDR[1:0],
                        ARADDR[ADDRW-1:SRAM_AW+2], ARADDR[1:0]};

endmodule

// File: tb/tb_sram_axi_slave.sv
// tb_sram_axi_slave: scoreboard bench for sram_axi_slave with a behavioural
// SRAM macro and a reference memory image.

module tb_sram_axi_slave;

    localparam int unsigned SAW = 14;
    localparam int unsigned SDW = 32;

`ifdef SRAM_AXI_SLAVE_RDATA_REG_EN
    localparam int RD_LAT = 1;
`else
    localparam int RD_LAT = 0;
`endif

    logic           ACLK;
    logic           ARESETn;
    logic [7:0]     AWID;
    logic [31:0]    AWADDR;
    logic [3:0]     AWLEN;
    logic [2:0]     AWSIZE;
    logic [1:0]     AWBURST;
    logic           AWVALID;
    logic           AWREADY;
    logic [31:0]    WDATA;
    logic [3:0]     WSTRB;
    logic           WLAST;
    logic           WVALID;
    logic           WREADY;
    logic [7:0]     BID;
    logic [1:0]     BRESP;
    logic           BVALID;
    logic           BREADY;
    logic [7:0]     ARID;
    logic [31:0]    ARADDR;
    logic [3:0]     ARLEN;
    logic [2:0]     ARSIZE;
    logic [1:0]     ARBURST;
    logic           ARVALID;
    logic           ARREADY;
    logic [7:0]     RID;
    logic [31:0]    RDATA;
    logic [1:0]     RRESP;
    logic           RLAST;
    logic           RVALID;
    logic           RREADY;
    logic           CEB;
    logic           WEB;
    logic [SDW-1:0] BWEB;
    logic [SAW-1:0] A;
    logic [SDW-1:0] DI;
    logic [SDW-1:0] DO;

    sram_axi_slave #(.SRAM_AW(SAW), .SRAM_DW(SDW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
        .RREADY(RREADY),
        .CEB(CEB), .WEB(WEB), .BWEB(BWEB), .A(A), .DI(DI), .DO(DO)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Behavioural single-port SRAM, 1-cycle read latency
    logic [SDW-1:0] mem [0:(1<<SAW)-1];
    always @(posedge ACLK) begin
        if (!CEB) begin
            if (!WEB) mem[A] <= (mem[A] & BWEB) | (DI & ~BWEB);
            else      DO     <= mem[A];
        end
    end

    logic [31:0] ref_mem [0:(1<<SAW)-1];
    logic [31:0] rd_q [$];
    logic [9:0]  b_q  [$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] burst, input int nbeats, input logic [31:0] d0,
                      input logic [3:0] strb, input bit collide);
        logic [SAW-1:0] w;
        logic [31:0]    mask;
        logic [31:0]    d;
        logic [9:0]     exp_b;
        int             cyc;
        w = addr[15:2];
        for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{strb[k]}};
        b_q.push_back({id, (nbeats - 1 == int'(len)) ? 2'b00 : 2'b10});
        AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWSIZE = 3'd2; AWVALID = 1'b1;
        if (collide) begin
            ARID = 8'h77; ARADDR = addr; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
        end
        @(negedge ACLK);
        check("awready", 32'(AWREADY), 32'd1);
        if (collide) check("arready_collide", 32'(ARREADY), 32'd0);
        tick();
        AWVALID = 1'b0;
        ARVALID = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            d = d0 + 32'(b) * 32'h0101_0101;
            WDATA = d; WSTRB = strb; WLAST = (b == nbeats - 1); WVALID = 1'b1;
            @(negedge ACLK);
            check("wready", 32'(WREADY), 32'd1);
            check("w_addr", 32'(A), 32'(w));
            check("w_ceb_web", {30'd0, CEB, WEB}, 32'd0);
            check("w_bweb", BWEB, ~mask);
            check("w_di", DI, d);
            ref_mem[w] = (ref_mem[w] & ~mask) | (d & mask);
            tick();
            if (burst != 2'b00) w = w + SAW'(1);
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        BREADY = 1'b1;
        cyc = 0;
        forever begin
            @(negedge ACLK);
            if (BVALID || cyc >= 20) break;
            tick();
            cyc++;
        end
        exp_b = b_q.pop_front();
        if (!BVALID) begin
            check("b_timeout", 32'(BVALID), 32'd1);
        end else begin
            check("bid", 32'(BID), 32'(exp_b[9:2]));
            check("bresp", 32'(BRESP), 32'(exp_b[1:0]));
            tick();
        end
        BREADY = 1'b0;
        @(negedge ACLK);
        check("idle_after_b", {30'd0, AWREADY, BVALID}, 32'd2);
        tick();
    endtask

    task automatic rd(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [1:0] burst, input int stall_beat, input int stall_cycles);
        logic [SAW-1:0] w;
        logic [SAW-1:0] hold_a;
        logic [31:0]    exp_d;
        int beat, cyc, first, stall;
        w = addr[15:2];
        for (int b = 0; b <= int'(len); b++) begin
            rd_q.push_back(ref_mem[w]);
            if (burst != 2'b00) w = w + SAW'(1);
        end
        ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARSIZE = 3'd2; ARVALID = 1'b1;
        @(negedge ACLK);
        check("arready", 32'(ARREADY), 32'd1);
        check("ar_ceb_web", {30'd0, CEB, WEB}, 32'd1);
        check("ar_addr", 32'(A), 32'(addr[15:2]));
        tick();
        ARVALID = 1'b0;
        beat = 0; cyc = 0; first = -1; stall = 0; hold_a = '0;
        while (beat <= int'(len) && cyc < 100) begin
            RREADY = (beat == stall_beat && stall < stall_cycles) ? 1'b0 : 1'b1;
            @(negedge ACLK);
            if (RVALID) begin
                if (first < 0) begin
                    first = cyc;
                    check("r_latency", 32'(first), 32'(RD_LAT));
                end
                if (!RREADY) begin
                    if (stall == 0) hold_a = A;
                    else check("r_hold_addr", 32'(A), 32'(hold_a));
                    check("r_hold_data", RDATA, rd_q[0]);
                    stall++;
                end else begin
                    exp_d = rd_q.pop_front();
                    check("rdata", RDATA, exp_d);
                    check("rid_rresp", {22'd0, RID, RRESP}, {22'd0, id, 2'b00});
                    check("rlast", 32'(RLAST), 32'(beat == int'(len)));
                    beat++;
                end
            end
            tick();
            cyc++;
        end
        RREADY = 1'b0;
        if (beat <= int'(len)) begin
            check("r_timeout", 32'(beat), 32'(len) + 32'd1);
            rd_q.delete();
        end
        @(negedge ACLK);
        check("rvalid_after_last", 32'(RVALID), 32'd0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;

        // Reset state
        @(negedge ACLK);
        @(negedge ACLK);
        check("rst_ready", {30'd0, AWREADY, ARREADY}, 32'd0);
        check("rst_valid", {28'd0, WREADY, BVALID, RVALID, RLAST}, 32'd0);
        check("rst_ceb_web", {30'd0, CEB, WEB}, 32'd3);
        check("rst_bweb", BWEB, 32'hFFFF_FFFF);
        check("rst_addr", 32'(A), 32'd0);
        check("rst_di", DI, 32'd0);
        tick();
        ARESETn = 1'b1;
        @(negedge ACLK);
        check("post_rst_ready", {30'd0, AWREADY, ARREADY}, 32'd3);
        tick();

        // Single write then read
        wr(8'h12, 32'h0000_0010, 4'd0, 2'b01, 1, 32'hDEAD_BEEF, 4'hF, 1'b0);
        rd(8'h34, 32'h0000_0010, 4'd0, 2'b01, -1, 0);

        // Byte strobe merge
        wr(8'h21, 32'h0000_0020, 4'd0, 2'b01, 1, 32'hFFFF_FFFF, 4'hF, 1'b0);
        wr(8'h22, 32'h0000_0020, 4'd0, 2'b01, 1, 32'h1122_3344, 4'b0101, 1'b0);
        rd(8'h23, 32'h0000_0020, 4'd0, 2'b01, -1, 0);

        // INCR burst, then read with backpressure on beat 1
        wr(8'h30, 32'h0000_0100, 4'd3, 2'b01, 4, 32'hA0B0_C0D0, 4'hF, 1'b0);
        rd(8'h31, 32'h0000_0100, 4'd3, 2'b01, 1, 3);

        // Collision plus address wrap at the top word
        wr(8'h40, 32'h0000_FFFC, 4'd1, 2'b01, 2, 32'h5500_AA00, 4'hF, 1'b1);
        rd(8'h41, 32'h0000_FFFC, 4'd1, 2'b01, -1, 0);

        // Length error: WLAST on beat 2 of a LEN=3 burst
        wr(8'h50, 32'h0000_0200, 4'd3, 2'b01, 2, 32'h0BAD_0001, 4'hF, 1'b0);

        // FIXED bursts hold the address
        rd(8'h60, 32'h0000_0100, 4'd2, 2'b00, -1, 0);
        wr(8'h61, 32'h0000_0300, 4'd1, 2'b00, 2, 32'h0F0F_0000, 4'hF, 1'b0);
        rd(8'h62, 32'h0000_0300, 4'd0, 2'b01, -1, 0);

        // Reset in the middle of a read burst
        ARID = 8'h70; ARADDR = 32'h0000_0100; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1;
        @(negedge ACLK);
        check("mid_arready", 32'(ARREADY), 32'd1);
        tick();
        ARVALID = 1'b0;
        RREADY = 1'b1;
        tick();
        #2;
        ARESETn = 1'b0;
        #1;
        check("mid_rst_ready", {30'd0, AWREADY, ARREADY}, 32'd0);
        check("mid_rst_rv", {30'd0, RVALID, RLAST}, 32'd0);
        check("mid_rst_ceb_web", {30'd0, CEB, WEB}, 32'd3);
        check("mid_rst_addr", 32'(A), 32'd0);
        tick();
        ARESETn = 1'b1;
        RREADY = 1'b0;
        @(negedge ACLK);
        check("mid_rst_idle", {29'd0, AWREADY, ARREADY, RVALID}, 32'd6);
        tick();

        // Normal operation after the abandoned burst
        rd(8'h71, 32'h0000_0010, 4'd0, 2'b01, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_axi_slave.md
Name: sram_axi_slave

Overview:
- AXI4 slave endpoint that sits downstream of the interconnect's S0/S1 slave ports and turns AXI bursts into accesses on a single-port synchronous SRAM macro (1-cycle read latency, active-low controls).
- Serves one transaction at a time (read or write); it is the standard wrapper instantiated per memory slave (IM, DM).

Parameters:
- SRAM_AW, 14, SRAM word-address width; the word index is ARADDR/AWADDR[SRAM_AW+1:2].
- SRAM_DW, 32, SRAM data width; equals `AXI_DATA_BITS.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset; asynchronous, active-low
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  `AXI_IDS_BITS/`AXI_ADDR_BITS/`AXI_LEN_BITS/`AXI_SIZE_BITS/2/1  write address channel
- AWREADY  out  1
- WDATA/WSTRB/WLAST/WVALID  in  `AXI_DATA_BITS/`AXI_STRB_BITS/1/1  write data channel
- WREADY  out  1
- BID/BRESP/BVALID  out  `AXI_IDS_BITS/2/1  write response channel
- BREADY  in  1
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  same widths as AW  read address channel
- ARREADY  out  1
- RID/RDATA/RRESP/RLAST/RVALID  out  `AXI_IDS_BITS/`AXI_DATA_BITS/2/1/1  read data channel
- RREADY  in  1
- CEB  out  1  SRAM chip enable, active-low
- WEB  out  1  SRAM write enable, active-low
- BWEB  out  SRAM_DW  per-bit write mask, active-low
- A  out  SRAM_AW  SRAM word address
- DI  out  SRAM_DW  SRAM write data
- DO  in  SRAM_DW  SRAM read data, valid the cycle after a read (CEB=0, WEB=1)

Behaviour:
- Reset (async, any state): FSM goes to IDLE; all AXI outputs 0; CEB=1, WEB=1, BWEB all 1s; A=0; DI=0; internal address/ID/length/beat registers cleared. An in-flight burst is abandoned and no response is issued.
- States: IDLE, RD, WR, WRESP.
- IDLE: AWREADY=1 and ARREADY=1 unless both AWVALID and ARVALID are 1, in which case the write wins (ARREADY=0).
  - AW handshake latches AWID, the word address, AWLEN and AWBURST, then goes to WR.
  - AR handshake latches ARID and ARLEN, drives A=ARADDR word index with CEB=0, WEB=1 in the same cycle, then goes to RD.
- RD:
  - RVALID=1, RDATA=DO, RID=latched ID, RRESP=2'b00, RLAST=1 when beat count == ARLEN.
  - CEB=0 for the whole state.
  - A is combinational: on (RVALID & RREADY & !RLAST) it drives the next-beat address; otherwise it holds the current address, so DO is re-read and stays stable under backpressure.
  - First RVALID appears the cycle after the AR handshake. One beat per cycle when RREADY=1.
  - The last-beat handshake returns to IDLE; RVALID=0 the next cycle.
- WR:
  - WREADY=1.
  - On WVALID: CEB=0, WEB=0, A=current word address, DI=WDATA, BWEB byte k = {8{~WSTRB[k]}}. Otherwise CEB=1, WEB=1.
  - Beat counter increments per beat. WLAST ends the burst and moves to WRESP.
- WRESP: BVALID=1, BID=latched AWID. BRESP=2'b00 if the beat count at WLAST == AWLEN, else 2'b10 (SLVERR). A BREADY handshake returns to IDLE.
- Address update:
  - AxBURST=2'b00 (FIXED): the address holds.
  - 2'b01 (INCR) and 2'b10 (WRAP, treated as INCR): word address +1, wrapping modulo 2^SRAM_AW (0x3FFF -> 0x0000).
  - AxSIZE is ignored; accesses are always full-word.
- Beat counter is `AXI_LEN_BITS wide; AxLEN=0 means a single beat.
- No new AR/AW is accepted outside IDLE (AWREADY=ARREADY=0).

Optional Feature:
- Macro SRAM_AXI_SLAVE_RDATA_REG_EN.
- Defined:
  - RDATA comes from a register loaded from DO; first RVALID is two cycles after the AR handshake.
  - The register loads only when it is empty or its beat handshakes, and A advances only on a load.
  - Throughput stays one beat per cycle; backpressure holds both RDATA and A.
- Undefined: RDATA=DO combinationally, with the 1-cycle latency described above.

Test Plan:
- Reset mid-burst: pull ARESETn low during an RD with ARLEN=3 -> outputs 0, CEB=1, WEB=1 immediately; IDLE after release; no RLAST seen.
- Single write then read: AW 0x0000_0010 ID=8'h12 LEN=0, WDATA=32'hDEADBEEF, WSTRB=4'hF, WLAST=1 -> A=14'h0004, WEB=0, BVALID with BID=8'h12, BRESP=0. Then AR same address -> RDATA=32'hDEADBEEF, RLAST=1, RVALID the cycle after AR.
- Byte strobe: write 32'h11223344 with WSTRB=4'b0101 over 32'hFFFFFFFF -> BWEB=32'hFF00FF00; readback 32'hFF22FF44.
- INCR read burst with backpressure: ARLEN=3 at 0x0000_0100, RREADY low on beat 1 for 3 cycles -> RDATA stable, A held, 4 beats in order, RLAST only on beat 4.
- Write/read collision and wrap: AWVALID and ARVALID in the same IDLE cycle -> AWREADY=1, ARREADY=0. INCR write of LEN=1 at word 0x3FFF -> second beat at A=0x0000.
- Length error: AWLEN=3 with WLAST on beat 2 -> BRESP=2'b10, return to IDLE after BREADY.
